// File: rtl/adc_decimator.sv
// adc_decimator: dual-channel ADC decimator producing DATA_OUT_A/B and the CLK_EN sample qualifier.
// Optional min/max peak-detect mode is compiled in when PEAK_DETECT_EN is defined.
module adc_decimator #(
  parameter int DIV_W = 24
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [7:0]       ADC_A,
  input  logic [7:0]       ADC_B,
  input  logic [DIV_W-1:0] Decim,
  input  logic             Peak_Mode,
  input  logic             Start_Write,
  output logic [7:0]       DATA_OUT_A,
  output logic [7:0]       DATA_OUT_B,
  output logic             CLK_EN,
  output logic             Peak_Is_Min
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_EMIT_MIN = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_l_r;
  logic [7:0]       a_q_r;
  logic [7:0]       b_q_r;
  logic [7:0]       data_a_r;
  logic [7:0]       data_b_r;
  logic             clk_en_r;
  logic             at_end_s;

  assign at_end_s = (cnt_r == div_l_r);

  // Input stage: all processing works on the registered samples.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      a_q_r <= 8'h00;
      b_q_r <= 8'h00;
    end else begin
      a_q_r <= ADC_A;
      b_q_r <= ADC_B;
    end
  end

`ifdef PEAK_DETECT_EN
  logic [7:0] max_a_r;
  logic [7:0] max_b_r;
  logic [7:0] min_a_r;
  logic [7:0] min_b_r;
  logic [7:0] hold_a_r;
  logic [7:0] hold_b_r;
  logic       is_min_r;
  logic [7:0] max_a_s;
  logic [7:0] max_b_s;
  logic [7:0] min_a_s;
  logic [7:0] min_b_s;
  logic       last_s;
  logic       peak_end_s;
  logic       track_upd_s;

  function automatic logic [7:0] umax8(input logic [7:0] x, input logic [7:0] y);
    umax8 = (x > y) ? x : y;
  endfunction

  function automatic logic [7:0] umin8(input logic [7:0] x, input logic [7:0] y);
    umin8 = (x < y) ? x : y;
  endfunction

  // Interval extremes including the sample currently held in a_q/b_q.
  always_comb begin
    max_a_s = umax8(max_a_r, a_q_r);
    max_b_s = umax8(max_b_r, b_q_r);
    min_a_s = umin8(min_a_r, a_q_r);
    min_b_s = umin8(min_b_r, b_q_r);
  end

  assign last_s = (state_r == ST_RUN) && Start_Write && at_end_s;

  // Single-sample intervals fall back to plain decimation even in peak mode.
  always_comb begin
    if (last_s && Peak_Mode && (div_l_r != CNT_ZERO)) begin
      peak_end_s = 1'b1;
    end else begin
      peak_end_s = 1'b0;
    end
  end

  assign track_upd_s = Start_Write &&
                       (((state_r == ST_RUN) && !at_end_s) ||
                        ((state_r == ST_EMIT_MIN) && (div_l_r != CNT_ZERO)));

  // Trackers follow every counted sample; any other cycle reseeds them.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      max_a_r <= 8'h00;
      max_b_r <= 8'h00;
      min_a_r <= 8'hFF;
      min_b_r <= 8'hFF;
    end else if (track_upd_s) begin
      max_a_r <= max_a_s;
      max_b_r <= max_b_s;
      min_a_r <= min_a_s;
      min_b_r <= min_b_s;
    end else begin
      max_a_r <= 8'h00;
      max_b_r <= 8'h00;
      min_a_r <= 8'hFF;
      min_b_r <= 8'hFF;
    end
  end

  // Minimum of the finished interval, emitted on the cycle after the max strobe.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      hold_a_r <= 8'hFF;
      hold_b_r <= 8'hFF;
    end else if (last_s) begin
      hold_a_r <= min_a_s;
      hold_b_r <= min_b_s;
    end else begin
      hold_a_r <= hold_a_r;
      hold_b_r <= hold_b_r;
    end
  end

  assign Peak_Is_Min = is_min_r;
`else
  logic unused_peak_mode_s;

  assign unused_peak_mode_s = Peak_Mode;
  assign Peak_Is_Min        = 1'b0;
`endif

  // Control FSM with registered strobe and sample outputs.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      div_l_r  <= CNT_ZERO;
      data_a_r <= 8'h00;
      data_b_r <= 8'h00;
      clk_en_r <= 1'b0;
`ifdef PEAK_DETECT_EN
      is_min_r <= 1'b0;
`endif
    end else begin
      clk_en_r <= 1'b0;
`ifdef PEAK_DETECT_EN
      is_min_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          cnt_r   <= CNT_ZERO;
          div_l_r <= Decim;
          if (Start_Write) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!Start_Write) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (at_end_s) begin
            cnt_r    <= CNT_ZERO;
            div_l_r  <= Decim;
            clk_en_r <= 1'b1;
`ifdef PEAK_DETECT_EN
            if (peak_end_s) begin
              data_a_r <= max_a_s;
              data_b_r <= max_b_s;
              state_r  <= ST_EMIT_MIN;
            end else begin
              data_a_r <= a_q_r;
              data_b_r <= b_q_r;
              state_r  <= ST_RUN;
            end
`else
            data_a_r <= a_q_r;
            data_b_r <= b_q_r;
            state_r  <= ST_RUN;
`endif
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef PEAK_DETECT_EN
        ST_EMIT_MIN: begin
          if (!Start_Write) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else begin
            data_a_r <= hold_a_r;
            data_b_r <= hold_b_r;
            clk_en_r <= 1'b1;
            is_min_r <= 1'b1;
            state_r  <= ST_RUN;
            // A one-sample interval latched at the boundary is consumed here without its own strobe.
            if (div_l_r == CNT_ZERO) begin
              cnt_r <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign DATA_OUT_A = data_a_r;
  assign DATA_OUT_B = data_b_r;
  assign CLK_EN     = clk_en_r;

endmodule
